// File: rtl/lut_multiplier_seq_pkg.sv
// Shared definitions for the byte-serial LUT multiplier: FSM state encoding and byte width.
package lut_multiplier_seq_pkg;

  localparam int BYTE = 8;

  typedef enum logic [1:0] {
    LMS_IDLE = 2'd0,
    LMS_CALC = 2'd1,
    LMS_DONE = 2'd2
  } lms_state_e;

endpackage

// File: rtl/lut_multiplier_8b.sv
// 8x8 unsigned multiplier primitive; the synthesis tool maps the product onto LUT logic.
module lut_multiplier_8b (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  assign p = a * b;

endmodule

// File: rtl/lut_multiplier_seq.sv
// Sequential WIDTH x WIDTH multiplier that walks the byte partial products through LANES
// 8x8 LUT multipliers, accumulating them, with valid/ready handshakes on both sides.
module lut_multiplier_seq
  import lut_multiplier_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LANES = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sign,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] mul
);

  localparam int N  = WIDTH / BYTE;
  localparam int P  = N * N;
  localparam int KW = $clog2(P) + 1;
  localparam int W2 = 2 * WIDTH;

  if ((WIDTH % BYTE) != 0 || WIDTH < 8 || WIDTH > 64) begin : g_bad_width
    $error("lut_multiplier_seq: WIDTH must be a multiple of 8 between 8 and 64");
  end
  if (LANES < 1 || (P % LANES) != 0) begin : g_bad_lanes
    $error("lut_multiplier_seq: LANES must divide (WIDTH/8)^2");
  end

  lms_state_e         state_q, state_d;
  logic [WIDTH-1:0]   a_mag_q, a_mag_d;
  logic [WIDTH-1:0]   b_mag_q, b_mag_d;
  logic               neg_q, neg_d;
  logic [W2-1:0]      acc_q, acc_d;
  logic [KW-1:0]      k_q, k_d;

  logic               accept;
  logic               last_step;
  logic [W2-1:0]      pp_sum;
  logic [W2-1:0]      result;
  logic [BYTE-1:0]    a_byte   [LANES];
  logic [BYTE-1:0]    b_byte   [LANES];
  logic [2*BYTE-1:0]  pp       [LANES];
  int                 pp_shift [LANES];

  // Lane m works on partial product k+m: byte i=(k+m)/N of A times byte j=(k+m)%N of B.
  always_comb begin : lane_select
    for (int m = 0; m < LANES; m++) begin
      a_byte[m]   = BYTE'(a_mag_q >> (BYTE * ((int'(k_q) + m) / N)));
      b_byte[m]   = BYTE'(b_mag_q >> (BYTE * ((int'(k_q) + m) % N)));
      pp_shift[m] = BYTE * (((int'(k_q) + m) / N) + ((int'(k_q) + m) % N));
    end
  end

  for (genvar m = 0; m < LANES; m++) begin : g_lane
    lut_multiplier_8b u_lut (
      .a (a_byte[m]),
      .b (b_byte[m]),
      .p (pp[m])
    );
  end

  always_comb begin : accumulate
    pp_sum = '0;
    for (int m = 0; m < LANES; m++) begin
      pp_sum = pp_sum + (W2'(pp[m]) << pp_shift[m]);
    end
  end

  assign last_step = (int'(k_q) + LANES) >= P;
  assign in_ready  = reset && ((state_q == LMS_IDLE) || ((state_q == LMS_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign result    = neg_q ? -acc_q : acc_q;
  assign out_valid = (state_q == LMS_DONE);
  assign mul       = (state_q == LMS_DONE) ? result : '0;

  always_comb begin : fsm_next
    state_d = state_q;
    a_mag_d = a_mag_q;
    b_mag_d = b_mag_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    k_d     = k_q;

    case (state_q)
      LMS_IDLE: ;
      LMS_CALC: begin
        acc_d = acc_q + pp_sum;
        k_d   = k_q + KW'(LANES);
        if (last_step) begin
          state_d = LMS_DONE;
        end
      end
      LMS_DONE: begin
        if (out_ready) begin
          state_d = LMS_IDLE;
        end
      end
      default: state_d = LMS_IDLE;
    endcase

    // Magnitudes of -2^(WIDTH-1) still fit unsigned in WIDTH bits, so the LUT path is purely unsigned.
    if (accept) begin
      a_mag_d = (sign && a[WIDTH-1]) ? -a : a;
      b_mag_d = (sign && b[WIDTH-1]) ? -b : b;
      neg_d   = sign && (a[WIDTH-1] ^ b[WIDTH-1]);
      acc_d   = '0;
      k_d     = '0;
      state_d = LMS_CALC;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LMS_IDLE;
      a_mag_q <= '0;
      b_mag_q <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_mag_q <= a_mag_d;
      b_mag_q <= b_mag_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
    end
  end

endmodule

// File: tb/tb_lut_multiplier_seq.sv
// Scoreboard bench for lut_multiplier_seq: a 16-bit single-lane instance for directed cases
// and a 32-bit two-lane instance for randomized handshake traffic.
module tb_lut_multiplier_seq;

  localparam int C16 = 4;
  localparam int C32 = 8;

  typedef struct {
    logic [63:0] prod;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;

  logic        in_valid16, in_ready16, sign16, out_valid16, out_ready16;
  logic [15:0] a16, b16;
  logic [31:0] mul16;

  logic        in_valid32, in_ready32, sign32, out_valid32, out_ready32;
  logic [31:0] a32, b32;
  logic [63:0] mul32;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t exp16[$];
  exp_t exp32[$];
  bit   ov16_prev = 1'b0;
  bit   ov32_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lut_multiplier_seq #(.WIDTH(16), .LANES(1)) dut16 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .a         (a16),
    .b         (b16),
    .sign      (sign16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .mul       (mul16)
  );

  lut_multiplier_seq #(.WIDTH(32), .LANES(2)) dut32 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid32),
    .in_ready  (in_ready32),
    .a         (a32),
    .b         (b32),
    .sign      (sign32),
    .out_valid (out_valid32),
    .out_ready (out_ready32),
    .mul       (mul32)
  );

  // Reference: sign-extend to 64 bits, multiply modulo 2^64, keep the low 2*w bits.
  function automatic logic [63:0] refProduct(input logic [31:0] x, input logic [31:0] y,
                                             input bit sgn, input int w);
    logic [63:0] xe, ye, mask;
    xe   = {32'd0, x};
    ye   = {32'd0, y};
    mask = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    if (sgn && x[w-1]) xe = xe | ~((64'd1 << w) - 64'd1);
    if (sgn && y[w-1]) ye = ye | ~((64'd1 << w) - 64'd1);
    return (xe * ye) & mask;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  // Output monitors: latency on each rising out_valid, product while valid, pop on handshake,
  // push the model result whenever the DUT accepts an operand pair.
  always @(negedge clk) begin
    if (!reset) begin
      ov16_prev = 1'b0;
    end else begin
      if (out_valid16 && !ov16_prev) begin
        if (exp16.size() == 0) checkOutput("sb16_empty", 64'(out_valid16), 64'd0);
        else checkOutput("lat16", 64'(cyc - exp16[0].cyc), 64'(C16 + 1));
      end
      if (out_valid16 && exp16.size() > 0) begin
        checkOutput("mul16", 64'(mul16), exp16[0].prod);
        if (!out_ready16) checkOutput("bp_rdy16", 64'(in_ready16), 64'd0);
        else void'(exp16.pop_front());
      end
      ov16_prev = out_valid16;
      if (in_valid16 && in_ready16)
        exp16.push_back('{prod: refProduct({16'd0, a16}, {16'd0, b16}, sign16, 16), cyc: cyc});
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      ov32_prev = 1'b0;
    end else begin
      if (out_valid32 && !ov32_prev) begin
        if (exp32.size() == 0) checkOutput("sb32_empty", 64'(out_valid32), 64'd0);
        else checkOutput("lat32", 64'(cyc - exp32[0].cyc), 64'(C32 + 1));
      end
      if (out_valid32 && exp32.size() > 0) begin
        checkOutput("mul32", mul32, exp32[0].prod);
        if (!out_ready32) checkOutput("bp_rdy32", 64'(in_ready32), 64'd0);
        else void'(exp32.pop_front());
      end
      ov32_prev = out_valid32;
      if (in_valid32 && in_ready32)
        exp32.push_back('{prod: refProduct(a32, b32, sign32, 32), cyc: cyc});
    end
  end

  task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y, input bit s);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    in_valid16 = 1'b1;
    a16        = x;
    b16        = y;
    sign16     = s;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready16;
    end
    checkOutput("accept16", 64'(ok), 64'd1);
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    a16        = 16'hDEAD;
    b16        = 16'hBEEF;
    sign16     = ~s;
  endtask

  task automatic waitDrain16();
    for (int t = 0; t < 100 && exp16.size() != 0; t++) @(negedge clk);
    checkOutput("drain16", 64'(exp16.size()), 64'd0);
  endtask

  task automatic waitDrain32();
    for (int t = 0; t < 200 && exp32.size() != 0; t++) @(negedge clk);
    checkOutput("drain32", 64'(exp32.size()), 64'd0);
  endtask

  task automatic waitValid16();
    for (int t = 0; t < 50 && !out_valid16; t++) @(negedge clk);
    checkOutput("wait_valid16", 64'(out_valid16), 64'd1);
  endtask

  logic [15:0] dirA [6] = '{16'hFFFF, 16'h8000, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h1234};
  logic [15:0] dirB [6] = '{16'hFFFF, 16'h8000, 16'h0003, 16'h8000, 16'h8000, 16'h0010};
  bit          dirS [6] = '{1'b0,     1'b1,     1'b1,     1'b1,     1'b1,     1'b0};

  initial begin
    int n;
    reset       = 1'b0;
    in_valid16  = 1'b0; a16 = '0; b16 = '0; sign16 = 1'b0; out_ready16 = 1'b1;
    in_valid32  = 1'b0; a32 = '0; b32 = '0; sign32 = 1'b0; out_ready32 = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ov16",  64'(out_valid16), 64'd0);
    checkOutput("rst_mul16", 64'(mul16),       64'd0);
    checkOutput("rst_rdy16", 64'(in_ready16),  64'd0);
    checkOutput("rst_rdy32", 64'(in_ready32),  64'd0);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    checkOutput("idle_rdy16", 64'(in_ready16), 64'd1);

    $display("[TB] directed 16-bit vectors");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(dirA[i], dirB[i], dirS[i]);
      waitDrain16();
    end

    $display("[TB] backpressure and back-to-back accept");
    out_ready16 = 1'b0;
    applyStimulus(16'hFFFF, 16'h0003, 1'b1);
    waitValid16();
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    out_ready16 = 1'b1;
    in_valid16  = 1'b1;
    a16         = 16'd2;
    b16         = 16'd3;
    sign16      = 1'b0;
    @(negedge clk);
    checkOutput("b2b_rdy16", 64'(in_ready16), 64'd1);
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    waitDrain16();

    $display("[TB] reset during CALC");
    applyStimulus(16'h4321, 16'h0F0F, 1'b0);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    checkOutput("rstcalc_ov16",  64'(out_valid16), 64'd0);
    checkOutput("rstcalc_mul16", 64'(mul16),       64'd0);
    checkOutput("rstcalc_rdy16", 64'(in_ready16),  64'd0);
    exp16.delete();
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    applyStimulus(16'h1234, 16'h0010, 1'b0);
    waitDrain16();

    $display("[TB] reset during DONE");
    out_ready16 = 1'b0;
    applyStimulus(16'h00FF, 16'h0101, 1'b1);
    waitValid16();
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rstdone_ov16",  64'(out_valid16), 64'd0);
    checkOutput("rstdone_mul16", 64'(mul16),       64'd0);
    exp16.delete();
    out_ready16 = 1'b1;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    applyStimulus(16'hFF01, 16'h00FF, 1'b1);
    waitDrain16();

    $display("[TB] random 32-bit traffic");
    n = 0;
    for (int t = 0; t < 40000 && n < 1000; t++) begin
      @(posedge clk); #1;
      in_valid32 = ($urandom_range(0, 3) != 0);
      a32        = $urandom;
      b32        = $urandom;
      sign32     = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0: a32 = 32'h8000_0000;
        1: b32 = 32'h0000_0000;
        2: a32 = 32'hFFFF_FFFF;
        3: b32 = 32'h8000_0000;
        default: ;
      endcase
      out_ready32 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid32 && in_ready32) n++;
    end
    checkOutput("rand_count32", 64'(n), 64'd1000);
    @(posedge clk); #1;
    in_valid32  = 1'b0;
    out_ready32 = 1'b1;
    waitDrain32();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
